// File: rtl/pe_simd_mac_if.sv
// Stream bus of the SIMD multiply-accumulate PE: input beats in, post-processed
// dot-product results out, each side with a valid/ready handshake.
interface pe_simd_mac_if #(
  parameter int N_LANE = 4,
  parameter int W_IN   = 8,
  parameter int W_OUT  = 8,
  parameter int W_CNT  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [N_LANE*W_IN-1:0]   a_vec;
  logic [N_LANE*W_IN-1:0]   b_vec;
  logic                     mode_sel;
  logic [4:0]               shift;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [W_OUT-1:0]  out_data;
  logic                     out_sat;
  logic [W_CNT-1:0]         out_count;

  modport master (
    output in_valid, in_last, a_vec, b_vec, mode_sel, shift, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_last, a_vec, b_vec, mode_sel, shift, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_count
  );
endinterface

// File: rtl/pe_simd_mac.sv
// SIMD MAC processing element: lane products (S1), accumulate (S2), shift/ReLU
// (S3) and saturating output register, all advancing together under one stall.
module pe_simd_mac #(
  parameter int N_LANE = 4,
  parameter int W_IN   = 8,
  parameter int W_ACC  = 32,
  parameter int W_OUT  = 8,
  parameter int W_CNT  = 16
) (
  input logic           clk,
  input logic           reset,
  pe_simd_mac_if.slave  bus
);
  localparam int W_P = 2 * W_IN;
  localparam logic signed [W_ACC-1:0] SAT_MAX = {{(W_ACC-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_ACC-1:0] SAT_MIN = {{(W_ACC-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

  logic adv;
  logic accept;
  logic acc_open_reg;

  logic                    s1_valid_reg;
  logic                    s1_last_reg;
  logic                    s1_first_reg;
  logic                    s1_mode_reg;
  logic [4:0]              s1_shift_reg;
  logic signed [W_P-1:0]   s1_prod_reg [N_LANE];
  logic signed [W_P-1:0]   prod_next   [N_LANE];
  logic signed [W_ACC-1:0] sum_next;

  logic                    s2_valid_reg;
  logic                    s2_mode_reg;
  logic [4:0]              s2_shift_reg;
  logic signed [W_ACC-1:0] acc_reg;
  logic [W_CNT-1:0]        cnt_reg;

  logic signed [W_ACC-1:0] shifted_next;
  logic signed [W_ACC-1:0] post_next;
  logic                    s3_valid_reg;
  logic signed [W_ACC-1:0] s3_val_reg;
  logic [W_CNT-1:0]        s3_cnt_reg;

  logic                    out_valid_reg;
  logic signed [W_OUT-1:0] out_data_reg;
  logic signed [W_OUT-1:0] out_data_next;
  logic                    out_sat_reg;
  logic                    out_sat_next;
  logic [W_CNT-1:0]        out_count_reg;

  // A single stall signal freezes every stage, so in_ready is simply adv.
  assign adv           = !out_valid_reg || bus.out_ready;
  assign accept        = bus.in_valid && adv;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sat   = out_sat_reg;
  assign bus.out_count = out_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_open_reg <= 1'b0;
    end else if (accept) begin
      acc_open_reg <= !bus.in_last;
    end
  end

  // Stage S1: one full-precision product per lane, activation zero-extended.
  generate
    for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane
      logic [W_IN-1:0] a_lane;
      logic [W_IN-1:0] b_lane;
      assign a_lane = bus.a_vec[gi*W_IN +: W_IN];
      assign b_lane = bus.b_vec[gi*W_IN +: W_IN];
      assign prod_next[gi] = $signed({{W_IN{1'b0}}, a_lane}) *
                             $signed({{W_IN{b_lane[W_IN-1]}}, b_lane});

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_prod_reg[gi] <= '0;
        end else if (accept) begin
          s1_prod_reg[gi] <= prod_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_first_reg <= 1'b0;
      s1_mode_reg  <= 1'b0;
      s1_shift_reg <= '0;
    end else if (adv) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_last_reg  <= bus.in_last;
        s1_first_reg <= !acc_open_reg;
        s1_mode_reg  <= bus.mode_sel;
        s1_shift_reg <= bus.shift;
      end
    end
  end

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < N_LANE; i++) begin
      sum_next = sum_next + W_ACC'(s1_prod_reg[i]);
    end
  end

  // Stage S2: accumulator wraps freely; only a closing beat marks S2 valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_mode_reg  <= 1'b0;
      s2_shift_reg <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
    end else if (adv) begin
      s2_valid_reg <= s1_valid_reg && s1_last_reg;
      if (s1_valid_reg) begin
        acc_reg      <= s1_first_reg ? sum_next : acc_reg + sum_next;
        cnt_reg      <= s1_first_reg ? W_CNT'(1) :
                        (&cnt_reg)   ? cnt_reg : cnt_reg + W_CNT'(1);
        s2_mode_reg  <= s1_mode_reg;
        s2_shift_reg <= s1_shift_reg;
      end
    end
  end

  always_comb begin
    shifted_next = acc_reg >>> s2_shift_reg;
    post_next    = shifted_next;
    if (s2_mode_reg && shifted_next < 0) begin
      post_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid_reg <= 1'b0;
      s3_val_reg   <= '0;
      s3_cnt_reg   <= '0;
    end else if (adv) begin
      s3_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        s3_val_reg <= post_next;
        s3_cnt_reg <= cnt_reg;
      end
    end
  end

  always_comb begin
    out_data_next = s3_val_reg[W_OUT-1:0];
    out_sat_next  = 1'b0;
    if (s3_val_reg > SAT_MAX) begin
      out_data_next = SAT_MAX[W_OUT-1:0];
      out_sat_next  = 1'b1;
    end else if (s3_val_reg < SAT_MIN) begin
      out_data_next = SAT_MIN[W_OUT-1:0];
      out_sat_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
      out_count_reg <= '0;
    end else if (adv) begin
      out_valid_reg <= s3_valid_reg;
      if (s3_valid_reg) begin
        out_data_reg  <= out_data_next;
        out_sat_reg   <= out_sat_next;
        out_count_reg <= s3_cnt_reg;
      end
    end
  end
endmodule

// File: tb/tb_pe_simd_mac.sv
// Directed bench for pe_simd_mac: latency, saturation, shift, sideband sampling,
// backpressure, mid-operation reset and streaming throughput.
module tb_pe_simd_mac;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  typedef struct {
    logic signed [7:0] data;
    logic              sat;
    logic [15:0]       cnt;
    int                stamp;
  } res_t;
  res_t rq[$];

  pe_simd_mac_if #(.N_LANE(4), .W_IN(8), .W_OUT(8), .W_CNT(16)) bus ();

  pe_simd_mac #(.N_LANE(4), .W_IN(8), .W_ACC(32), .W_OUT(8), .W_CNT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Record every result handed over downstream, with the cycle it left.
  always @(posedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      rq.push_back('{data: bus.out_data, sat: bus.out_sat, cnt: bus.out_count, stamp: cyc});
      $display("result data=%0d sat=%0d count=%0d cycle=%0d", bus.out_data, bus.out_sat, bus.out_count, cyc);
    end
    cyc++;
  end

  function automatic logic [31:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic mode,
                                input logic [4:0] sh, output int d, output logic s);
    int sum = 0;
    int v;
    for (int j = 0; j < 4; j++) begin
      sum += int'(a[8*j +: 8]) * int'($signed(b[8*j +: 8]));
    end
    v = sum >>> sh;
    if (mode && v < 0) v = 0;
    s = 1'b0;
    if (v > 127) begin v = 127; s = 1'b1; end
    else if (v < -128) begin v = -128; s = 1'b1; end
    d = v;
  endfunction

  // Present one beat from a negedge; returns on the negedge after acceptance.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last,
                           input logic mode, input logic [4:0] sh);
    logic got = 1'b0;
    int   k = 0;
    bus.a_vec = a; bus.b_vec = b; bus.in_last = last;
    bus.mode_sel = mode; bus.shift = sh; bus.in_valid = 1'b1;
    while (!got && k < 100) begin
      #1;
      got = bus.in_ready;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_beat: beat not accepted, got timeout after %0d cycles, required acceptance", k);
    end
    $display("beat a=%h b=%h last=%0d mode=%0d shift=%0d", a, b, last, mode, sh);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_results(input int n, input string tag);
    int k = 0;
    while (rq.size() < n && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rq.size() < n) begin
      errors++;
      $display("FAIL %s result count: got %0d, required %0d", tag, rq.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0 || bus.out_sat !== 1'b0 || bus.out_count !== 16'd0) begin
      errors++;
      $display("FAIL reset outputs: got valid=%0d data=%0d sat=%0d count=%0d, required all 0",
               bus.out_valid, bus.out_data, bus.out_sat, bus.out_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %0d, required 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    int lat = 0;
    rq.delete();
    bus.out_ready = 1'b1;
    send_beat(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1, 1'b0, 5'd0);
    idle();
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL single latency: got %0d edges, required 3", lat);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single out_valid pulse: got %0d one cycle later, required 0", bus.out_valid);
    end
    @(negedge clk);
    wait_results(1, "single");
    if (rq.size() > 0) begin
      checks++;
      if (rq[0].data !== 8'sd10 || rq[0].sat !== 1'b0 || rq[0].cnt !== 16'd1) begin
        errors++;
        $display("FAIL single result: got data=%0d sat=%0d count=%0d, required 10 0 1",
                 rq[0].data, rq[0].sat, rq[0].cnt);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] a = pack4(255, 255, 255, 255);
    logic [31:0] b = pack4(-128, -128, -128, -128);
    rq.delete();
    // Non-last beats carry the opposite mode to show only the last beat's mode counts.
    send_beat(a, b, 1'b0, 1'b1, 5'd0);
    send_beat(a, b, 1'b0, 1'b1, 5'd0);
    send_beat(a, b, 1'b1, 1'b0, 5'd0);
    send_beat(a, b, 1'b0, 1'b0, 5'd0);
    send_beat(a, b, 1'b0, 1'b0, 5'd0);
    send_beat(a, b, 1'b1, 1'b1, 5'd0);
    idle();
    wait_results(2, "saturation");
    if (rq.size() > 1) begin
      checks++;
      if (rq[0].data !== -8'sd128 || rq[0].sat !== 1'b1 || rq[0].cnt !== 16'd3) begin
        errors++;
        $display("FAIL sat raw: got data=%0d sat=%0d count=%0d, required -128 1 3",
                 rq[0].data, rq[0].sat, rq[0].cnt);
      end
      checks++;
      if (rq[1].data !== 8'sd0 || rq[1].sat !== 1'b0 || rq[1].cnt !== 16'd3) begin
        errors++;
        $display("FAIL sat relu: got data=%0d sat=%0d count=%0d, required 0 0 3",
                 rq[1].data, rq[1].sat, rq[1].cnt);
      end
    end
  endtask

  task automatic test_shift();
    rq.delete();
    send_beat(pack4(250, 0, 0, 0), pack4(4, 0, 0, 0), 1'b1, 1'b0, 5'd3);
    send_beat(pack4(250, 0, 0, 0), pack4(-4, 0, 0, 0), 1'b1, 1'b0, 5'd3);
    send_beat(pack4(7, 0, 0, 0), pack4(-1, 0, 0, 0), 1'b1, 1'b0, 5'd1);
    // Two-beat product whose first beat asks for shift 5 and ReLU; the last beat does not.
    send_beat(pack4(10, 0, 0, 0), pack4(-1, 0, 0, 0), 1'b0, 1'b1, 5'd5);
    send_beat(pack4(5, 0, 0, 0), pack4(-1, 0, 0, 0), 1'b1, 1'b0, 5'd0);
    idle();
    wait_results(4, "shift");
    if (rq.size() > 3) begin
      checks++;
      if (rq[0].data !== 8'sd125 || rq[0].sat !== 1'b0) begin
        errors++;
        $display("FAIL shift pos: got data=%0d sat=%0d, required 125 0", rq[0].data, rq[0].sat);
      end
      checks++;
      if (rq[1].data !== -8'sd125 || rq[1].sat !== 1'b0) begin
        errors++;
        $display("FAIL shift neg: got data=%0d sat=%0d, required -125 0", rq[1].data, rq[1].sat);
      end
      checks++;
      if (rq[2].data !== -8'sd4) begin
        errors++;
        $display("FAIL shift floor: got data=%0d, required -4", rq[2].data);
      end
      checks++;
      if (rq[3].data !== -8'sd15 || rq[3].cnt !== 16'd2) begin
        errors++;
        $display("FAIL sideband sample: got data=%0d count=%0d, required -15 2", rq[3].data, rq[3].cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    rq.delete();
    bus.out_ready = 1'b0;
    send_beat(pack4(10, 0, 0, 0), pack4(1, 0, 0, 0), 1'b1, 1'b0, 5'd0);
    send_beat(pack4(20, 0, 0, 0), pack4(1, 0, 0, 0), 1'b1, 1'b0, 5'd0);
    send_beat(pack4(30, 0, 0, 0), pack4(1, 0, 0, 0), 1'b1, 1'b0, 5'd0);
    idle();
    while (!bus.out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    bus.a_vec = pack4(40, 0, 0, 0); bus.b_vec = pack4(1, 0, 0, 0);
    bus.in_last = 1'b1; bus.mode_sel = 1'b0; bus.shift = 5'd0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'sd10 ||
          bus.out_sat !== 1'b0 || bus.out_count !== 16'd1) begin
        errors++;
        $display("FAIL stall hold %0d: got ready=%0d valid=%0d data=%0d sat=%0d count=%0d, required 0 1 10 0 1",
                 i, bus.in_ready, bus.out_valid, bus.out_data, bus.out_sat, bus.out_count);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    idle();
    wait_results(4, "backpressure");
    repeat (4) @(negedge clk);
    checks++;
    if (rq.size() !== 4) begin
      errors++;
      $display("FAIL backpressure count: got %0d results, required 4", rq.size());
    end
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      checks++;
      if (int'(rq[i].data) !== 10 * (i + 1)) begin
        errors++;
        $display("FAIL backpressure order %0d: got %0d, required %0d", i, rq[i].data, 10 * (i + 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    rq.delete();
    send_beat(pack4(9, 9, 9, 9), pack4(1, 1, 1, 1), 1'b0, 1'b0, 5'd0);
    send_beat(pack4(9, 9, 9, 9), pack4(1, 1, 1, 1), 1'b0, 1'b0, 5'd0);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid in_ready: got %0d, required 1", bus.in_ready);
    end
    @(negedge clk);
    send_beat(pack4(1, 0, 0, 0), pack4(5, 0, 0, 0), 1'b1, 1'b0, 5'd0);
    idle();
    wait_results(1, "reset_mid");
    if (rq.size() > 0) begin
      checks++;
      if (rq[0].data !== 8'sd5 || rq[0].cnt !== 16'd1 || rq[0].sat !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid result: got data=%0d count=%0d sat=%0d, required 5 1 0",
                 rq[0].data, rq[0].cnt, rq[0].sat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          exp_d [8];
    logic        exp_s [8];
    logic [31:0] a, b;
    rq.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = pack4((i * 37) & 255, (i * 37 + 11) & 255, (i * 37 + 22) & 255, (i * 37 + 33) & 255);
      b = pack4((i * 53) & 255, (i * 53 + 29) & 255, (i * 53 + 58) & 255, (i * 53 + 87) & 255);
      model(a, b, i[0], 5'(i % 4), exp_d[i], exp_s[i]);
      send_beat(a, b, 1'b1, i[0], 5'(i % 4));
    end
    idle();
    wait_results(8, "stream");
    for (int i = 0; i < 8 && i < rq.size(); i++) begin
      checks++;
      if (int'(rq[i].data) !== exp_d[i] || rq[i].sat !== exp_s[i] || rq[i].cnt !== 16'd1) begin
        errors++;
        $display("FAIL stream %0d: got data=%0d sat=%0d count=%0d, required %0d %0d 1",
                 i, rq[i].data, rq[i].sat, rq[i].cnt, exp_d[i], exp_s[i]);
      end
      if (i > 0) begin
        checks++;
        if (rq[i].stamp !== rq[i-1].stamp + 1) begin
          errors++;
          $display("FAIL stream spacing %0d: got cycle %0d, required %0d", i, rq[i].stamp, rq[i-1].stamp + 1);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.a_vec = '0; bus.b_vec = '0;
    bus.mode_sel = 1'b0; bus.shift = '0; bus.out_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_saturation();
    test_shift();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_simd_mac.md
PE_SIMD_MAC -- requirements
Module: pe_simd_mac

Interface
REQ-001 Parameter N_LANE, default 4: number of parallel multiply lanes per beat; legal range 1..16.
REQ-002 Parameter W_IN, default 8: operand width per lane.
REQ-003 Parameter W_ACC, default 32: accumulator width; must be at least 2*W_IN+$clog2(N_LANE).
REQ-004 Parameter W_OUT, default 8: signed output width; must be at most W_ACC.
REQ-005 Parameter W_CNT, default 16: beat-counter width.
REQ-006 Port clk  input  1  clock; all registers are rising-edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Port in_valid  input  1  input beat valid.
REQ-009 Port in_ready  output  1  block accepts a beat this cycle.
REQ-010 Port in_last  input  1  the beat closes the current dot product.
REQ-011 Port a_vec  input  N_LANE*W_IN  unsigned activations; lane i is bits [i*W_IN +: W_IN].
REQ-012 Port b_vec  input  N_LANE*W_IN  signed weights, same lane packing as a_vec.
REQ-013 Port mode_sel  input  1  output mode: 0 = raw, 1 = ReLU; sampled with the in_last beat.
REQ-014 Port shift  input  5  arithmetic right-shift amount; sampled with the in_last beat.
REQ-015 Port out_valid  output  1  result valid.
REQ-016 Port out_ready  input  1  downstream accepts the result.
REQ-017 Port out_data  output  W_OUT  signed post-processed result.
REQ-018 Port out_sat  output  1  out_data was clipped.
REQ-019 Port out_count  output  W_CNT  number of beats in this dot product; saturates at all-ones.

Function
REQ-020 A beat is accepted when in_valid && in_ready.
REQ-021 Pipeline advance: adv = !out_valid || out_ready.
- When adv=0, every stage holds its contents, including the valid bits.
- in_ready SHALL equal adv.
REQ-022 Stage S1 registers the lane products signed({1'b0,a_i}) * signed(b_i). Each product is exactly 2*W_IN bits, with no truncation.
REQ-023 Stage S2 sign-extends and sums all N_LANE products, then adds the sum into the accumulator.
- On the first beat of a dot product, the accumulator loads the sum instead of adding to it.
- The first beat is the first beat after reset or after an in_last beat.
REQ-024 The accumulator wraps modulo 2^W_ACC; no saturation is applied at this stage.
REQ-025 The beat counter rules:
- Loads 1 on the first beat.
- Increments on each further beat.
- Holds at 2^W_CNT-1 once it reaches that value.
REQ-026 Stage S3 acts only on the in_last beat, in this order:
- Arithmetic right shift of the accumulator by shift (floor).
- If mode_sel=1, negative values become 0.
- Saturate to the signed range [-2^(W_OUT-1), 2^(W_OUT-1)-1].
- Register the result into out_data, with out_sat = 1 if clipping occurred.
REQ-027 Latency: an in_last beat accepted at edge t produces out_valid=1 after edge t+3 when no stall occurs.
- Non-last beats never raise out_valid.
REQ-028 out_valid, out_data, out_sat and out_count SHALL hold stable while out_valid && !out_ready.
REQ-029 With out_ready held at 1, the block sustains one beat per cycle.
- Back-to-back dot products need no bubble.
- A beat carrying in_last on every cycle gives one result per cycle.
REQ-030 mode_sel and shift travel down the pipeline with their beat. Changing them mid-dot-product has no effect until an in_last beat samples them.
REQ-031 The first-beat flag is tracked in a register (acc_open). It sets on an accepted non-last beat and clears on an accepted in_last beat.

Reset
REQ-032 While reset=1, all registers clear: pipeline valid bits, accumulator, counter, acc_open, out_valid, out_data, out_sat and out_count all go to 0.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-034 Reset asserted mid-dot-product discards the partial sum. The next accepted beat is treated as a first beat.

Verification
REQ-035 Single-beat dot product: N_LANE=4, a=[1,2,3,4], b=[1,1,1,1], in_last=1, mode 0, shift 0 -> out_data=10, out_sat=0, out_count=1, out_valid exactly 3 cycles after acceptance.
REQ-036 Saturation test: 3 beats of a=255, b=-128 on all lanes (accumulator -391680), mode 0 -> out_data=-128, out_sat=1, out_count=3. The same stimulus with mode 1 -> out_data=0, out_sat=0.
REQ-037 Shift test: accumulator 1000 with shift 3 -> 125. Accumulator -1000 with shift 3 -> -125. Both give out_sat=0.
REQ-038 Backpressure: hold out_ready=0 with a result pending.
- in_ready drops to 0 and stays 0.
- Outputs stay stable.
- Beats presented during the stall are not accepted.
- Releasing out_ready delivers all results in order, with no loss or duplication.
REQ-039 Reset mid-operation: send 2 non-last beats, pulse reset, then send one last beat with a=[1,0,0,0], b=[5,0,0,0] -> out_data=5, out_count=1.
REQ-040 Streaming: 8 consecutive single-beat dot products with out_ready=1 -> 8 results on 8 consecutive cycles, each matching the reference model.
